// File: rtl/id_scoreboard_pkg.sv
// Shared sizing and entry payload for the decode register-hazard scoreboard.
package id_scoreboard_pkg;

  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 2;

  localparam logic [REG_AW-1:0] R0      = '0;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             late;
  } sb_entry_t;

endpackage

// File: rtl/id_scoreboard_sb_entry.sv
// One scoreboard slot: in-flight writer count plus late-producer flag.
module id_scoreboard_sb_entry
  import id_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             issue,
  input  logic             issue_late,
  input  logic             retire,
  input  logic             done,
  input  logic             flush,
  output logic [CNT_W-1:0] cnt,
  output logic             late
);

  // Issue and retire in the same cycle cancel; the youngest issue owns the late flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      late <= 1'b0;
    end else if (flush) begin
      cnt  <= '0;
      late <= 1'b0;
    end else begin
      if (issue && !retire) begin
        cnt <= cnt + CNT_W'(1);
      end else if (retire && !issue && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (issue) begin
        late <= issue_late;
      end else if (done) begin
        late <= 1'b0;
      end
    end
  end

  a_retire_nonempty: assert property (
    @(posedge clk) disable iff (reset) (retire && !flush) |-> (cnt != '0)
  );

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage register-hazard scoreboard: stall and busy hints gating ID->EX issue.
module id_scoreboard
  import id_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rj,
  input  logic [REG_AW-1:0] id_rkd,
  input  logic              id_need_r1,
  input  logic              id_need_r2,
  input  logic              id_we,
  input  logic [REG_AW-1:0] id_waddr,
  input  logic              id_late,
  input  logic              ex_allowin,
  input  logic              late_done,
  input  logic [REG_AW-1:0] late_waddr,
  input  logic              wb_retire,
  input  logic [REG_AW-1:0] wb_waddr,
  input  logic              flush,
  output logic              id_stall,
  output logic              id_issue,
  output logic              rj_busy,
  output logic              rkd_busy,
  output logic              sb_empty
);

  sb_entry_t ent [NREG];
  logic      do_write;

  assign ent[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_entry
    logic [CNT_W-1:0] c;
    logic             l;

    id_scoreboard_sb_entry u_entry (
      .clk        (clk),
      .reset      (reset),
      .issue      (do_write && (id_waddr == REG_AW'(i))),
      .issue_late (id_late),
      .retire     (wb_retire && (wb_waddr == REG_AW'(i))),
      .done       (late_done && (late_waddr == REG_AW'(i))),
      .flush      (flush),
      .cnt        (c),
      .late       (l)
    );

    assign ent[i] = '{cnt: c, late: l};
  end

  // Hazard detection: late RAW, counter overflow, and a second in-flight late writer.
  always_comb begin
    logic raw_late;
    logic ovf;
    logic waw_late;
    raw_late = (id_need_r1 && ent[id_rj].late) || (id_need_r2 && ent[id_rkd].late);
    ovf      = id_we && (id_waddr != R0) && (ent[id_waddr].cnt == CNT_MAX);
    waw_late = id_we && id_late && ent[id_waddr].late;
    id_stall = id_valid && (raw_late || ovf || waw_late);
  end

  assign id_issue = id_valid && !id_stall && ex_allowin && !flush && !reset;
  assign do_write = id_issue && id_we && (id_waddr != R0);
  assign rj_busy  = (ent[id_rj].cnt != '0);
  assign rkd_busy = (ent[id_rkd].cnt != '0);

  always_comb begin
    sb_empty = 1'b1;
    for (int i = 1; i < NREG; i++) begin
      if (ent[i].cnt != '0) sb_empty = 1'b0;
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Randomized and directed checks of id_scoreboard against a counting reference model.
module tb_id_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_need_r1, id_need_r2, id_we, id_late, ex_allowin;
  logic [4:0] id_rj, id_rkd, id_waddr, late_waddr, wb_waddr;
  logic       late_done, wb_retire, flush;
  logic       id_stall, id_issue, rj_busy, rkd_busy, sb_empty;

  int checks   = 0;
  int failures = 0;
  int m_cnt [32];
  bit m_late [32];

  localparam int MAXW = 3;

  id_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rj(id_rj), .id_rkd(id_rkd),
    .id_need_r1(id_need_r1), .id_need_r2(id_need_r2), .id_we(id_we), .id_waddr(id_waddr),
    .id_late(id_late), .ex_allowin(ex_allowin), .late_done(late_done),
    .late_waddr(late_waddr), .wb_retire(wb_retire), .wb_waddr(wb_waddr), .flush(flush),
    .id_stall(id_stall), .id_issue(id_issue), .rj_busy(rj_busy), .rkd_busy(rkd_busy),
    .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_need_r1 = 0; id_need_r2 = 0; id_we = 0; id_late = 0;
    ex_allowin = 0; late_done = 0; wb_retire = 0; flush = 0;
    id_rj = 0; id_rkd = 0; id_waddr = 0; late_waddr = 0; wb_waddr = 0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_cnt[i] = 0;
      m_late[i] = 0;
    end
  endtask

  // Check combinational outputs against the model, then advance one clock and update it.
  task automatic cycle();
    bit raw, ovf, waw, st, iss, empty;
    #1;
    raw = (id_need_r1 && m_late[id_rj]) || (id_need_r2 && m_late[id_rkd]);
    ovf = id_we && id_waddr != 0 && m_cnt[id_waddr] == MAXW;
    waw = id_we && id_late && m_late[id_waddr];
    st  = id_valid && (raw || ovf || waw);
    iss = id_valid && !st && ex_allowin && !flush;
    empty = 1;
    for (int i = 1; i < 32; i++) if (m_cnt[i] != 0) empty = 0;
    check("id_stall", 32'(id_stall), 32'(st));
    check("id_issue", 32'(id_issue), 32'(iss));
    check("rj_busy",  32'(rj_busy),  32'(m_cnt[id_rj] != 0));
    check("rkd_busy", 32'(rkd_busy), 32'(m_cnt[id_rkd] != 0));
    check("sb_empty", 32'(sb_empty), 32'(empty));
    @(posedge clk);
    if (flush) begin
      model_clear();
    end else begin
      if (late_done && late_waddr != 0) m_late[late_waddr] = 0;
      if (wb_retire && wb_waddr != 0 && m_cnt[wb_waddr] > 0) m_cnt[wb_waddr]--;
      if (iss && id_we && id_waddr != 0) begin
        m_cnt[id_waddr]++;
        m_late[id_waddr] = id_late;
      end
    end
    @(negedge clk);
  endtask

  task automatic write(input int r, input bit lt);
    idle(); id_valid = 1; ex_allowin = 1; id_we = 1; id_waddr = 5'(r); id_late = lt;
  endtask

  task automatic read1(input int r);
    idle(); id_valid = 1; ex_allowin = 1; id_need_r1 = 1; id_rj = 5'(r);
  endtask

  task automatic retire(input int r);
    idle(); wb_retire = 1; wb_waddr = 5'(r);
  endtask

  initial begin
    int q [$];
    model_clear();
    idle();
    reset = 1;
    id_valid = 1; ex_allowin = 1; id_we = 1; id_waddr = 5'd5;
    #2;
    check("rst_stall", 32'(id_stall), 0);
    check("rst_issue", 32'(id_issue), 0);
    check("rst_empty", 32'(sb_empty), 1);
    @(negedge clk); @(negedge clk);
    reset = 0;
    idle();

    // Plain writer, reader sees busy, retire empties the board.
    write(5, 0); cycle();
    read1(5); #1 check("r5_busy", 32'(rj_busy), 1); cycle();
    retire(5); cycle();
    idle(); #1 check("r5_empty", 32'(sb_empty), 1); cycle();

    // Load producer blocks a dependent reader until late_done.
    write(4, 1); cycle();
    read1(4); #1 check("ld_stall", 32'(id_stall), 1); check("ld_issue", 32'(id_issue), 0); cycle();
    idle(); late_done = 1; late_waddr = 5'd4; cycle();
    read1(4); #1 check("ld_go", 32'(id_issue), 1); cycle();
    retire(4); cycle();

    // Counter saturation on r7, retire in the same cycle does not release the stall.
    for (int k = 0; k < 3; k++) begin write(7, 0); cycle(); end
    write(7, 0); #1 check("r7_full", 32'(id_stall), 1); cycle();
    write(7, 0); wb_retire = 1; wb_waddr = 5'd7;
    #1 check("r7_full_ret", 32'(id_stall), 1); cycle();
    write(7, 0); #1 check("r7_free", 32'(id_stall), 0); cycle();
    for (int k = 0; k < 3; k++) begin retire(7); cycle(); end

    // Simultaneous issue and retire leave the count unchanged.
    write(9, 0); cycle();
    write(9, 0); wb_retire = 1; wb_waddr = 5'd9; cycle();
    read1(9); #1 check("r9_busy", 32'(rj_busy), 1); cycle();
    retire(9); cycle();
    read1(9); #1 check("r9_idle", 32'(rj_busy), 0); cycle();

    // r0 is never tracked.
    write(0, 1); cycle();
    read1(0); #1 check("r0_busy", 32'(rj_busy), 0); check("r0_stall", 32'(id_stall), 0); cycle();

    // Flush overrides a same-cycle issue.
    write(3, 0); cycle();
    write(3, 1); cycle();
    write(3, 0); flush = 1; #1 check("fl_issue", 32'(id_issue), 0); cycle();
    idle(); #1 check("fl_empty", 32'(sb_empty), 1); cycle();

    // Randomized traffic with legal retires and late_done.
    for (int n = 0; n < 600; n++) begin
      idle();
      id_valid   = 1'($urandom_range(0, 1));
      ex_allowin = ($urandom_range(0, 3) != 0);
      id_need_r1 = 1'($urandom_range(0, 1));
      id_need_r2 = 1'($urandom_range(0, 1));
      id_we      = 1'($urandom_range(0, 1));
      id_late    = ($urandom_range(0, 2) == 0);
      id_rj      = 5'($urandom_range(0, 7));
      id_rkd     = 5'($urandom_range(0, 7));
      id_waddr   = 5'($urandom_range(0, 7));
      q.delete();
      for (int i = 1; i < 32; i++) if (m_cnt[i] > 0) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
        wb_retire = 1;
        wb_waddr  = 5'(q[$urandom_range(0, q.size() - 1)]);
      end
      q.delete();
      for (int i = 1; i < 32; i++) if (m_late[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 1) != 0) begin
        late_done  = 1;
        late_waddr = 5'(q[$urandom_range(0, q.size() - 1)]);
      end
      flush = ($urandom_range(0, 40) == 0);
      cycle();
    end

    // Reset asserted mid-traffic forces reset outputs immediately.
    write(2, 0); cycle();
    write(2, 1); id_need_r1 = 1; id_rj = 5'd2; id_rkd = 5'd2;
    #2 reset = 1;
    #1;
    check("mid_issue", 32'(id_issue), 0);
    check("mid_stall", 32'(id_stall), 0);
    check("mid_rj",    32'(rj_busy),  0);
    check("mid_rkd",   32'(rkd_busy), 0);
    check("mid_empty", 32'(sb_empty), 1);
    model_clear();
    @(negedge clk);
    reset = 0;
    write(6, 0); cycle();
    read1(6); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
